// File: rtl/joy_db15_tx.sv
// joy_db15_tx: DB15 joystick adapter emulator, parallel-load then serial shift on JOY_CLK.
// Define JOY_DB15_TX_STATS_EN to add the frame_cnt and short_frame outputs.
module joy_db15_tx #(
  parameter int FRAME_BITS  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] joystick1,
  input  logic [11:0] joystick2,
  input  logic        JOY_LOAD,
  input  logic        JOY_CLK,
  output logic        JOY_DATA,
  output logic        frame_done,
  output logic [4:0]  bit_cnt
`ifdef JOY_DB15_TX_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic        short_frame
`endif
);
  logic [SYNC_STAGES-1:0] load_s_q, clk_s_q;
  logic                   clk_prev_q;
  logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic                   done_q, done_d;
  logic                   ld, shift;
  always_comb begin
    ld        = ~load_s_q[SYNC_STAGES-1];
    shift     = ~ld & clk_s_q[SYNC_STAGES-1] & ~clk_prev_q;
    shreg_d   = ld ? FRAME_BITS'({~joystick2, ~joystick1}) :
                shift ? {1'b1, shreg_q[FRAME_BITS-1:1]} : shreg_q;
    bit_cnt_d = ld ? 5'd0 :
                (shift && bit_cnt_q != 5'(FRAME_BITS)) ? bit_cnt_q + 5'd1 : bit_cnt_q;
    done_d    = shift & (bit_cnt_q == 5'(FRAME_BITS - 1));
  end
  // Sync chains idle high so reset never looks like a load or a clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_s_q   <= '1;
      clk_s_q    <= '1;
      clk_prev_q <= 1'b1;
      shreg_q    <= '1;
      bit_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      load_s_q   <= {load_s_q[SYNC_STAGES-2:0], JOY_LOAD};
      clk_s_q    <= {clk_s_q[SYNC_STAGES-2:0], JOY_CLK};
      clk_prev_q <= clk_s_q[SYNC_STAGES-1];
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      done_q     <= done_d;
    end
  end
  assign JOY_DATA   = shreg_q[0];
  assign frame_done = done_q;
  assign bit_cnt    = bit_cnt_q;
`ifdef JOY_DB15_TX_STATS_EN
  logic [15:0] frame_cnt_q;
  logic        short_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      short_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_q + {15'd0, done_d};
      short_q     <= short_q | (ld && bit_cnt_q != 5'd0 && bit_cnt_q < 5'(FRAME_BITS));
    end
  end
  assign frame_cnt   = frame_cnt_q;
  assign short_frame = short_q;
`endif
endmodule

// File: tb/tb_joy_db15_tx.sv
// tb_joy_db15_tx: directed-vector bench for joy_db15_tx.
module tb_joy_db15_tx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] joystick1 = '0;
  logic [11:0] joystick2 = '0;
  logic        JOY_LOAD = 1'b1;
  logic        JOY_CLK = 1'b0;
  logic        JOY_DATA, frame_done;
  logic [4:0]  bit_cnt;
`ifdef JOY_DB15_TX_STATS_EN
  logic [15:0] frame_cnt;
  logic        short_frame;
`endif
  int vectors = 0, errors = 0, done_cnt = 0, d0 = 0;

  joy_db15_tx dut (
    .clk(clk), .reset(reset), .joystick1(joystick1), .joystick2(joystick2),
    .JOY_LOAD(JOY_LOAD), .JOY_CLK(JOY_CLK), .JOY_DATA(JOY_DATA),
    .frame_done(frame_done), .bit_cnt(bit_cnt)
`ifdef JOY_DB15_TX_STATS_EN
    , .frame_cnt(frame_cnt), .short_frame(short_frame)
`endif
  );

  always #10 clk = ~clk;
  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    JOY_CLK = 1'b1;
    tick(4);
    JOY_CLK = 1'b0;
    tick(4);
  endtask

  task automatic load();
    JOY_LOAD = 1'b0;
    tick(4);
    JOY_LOAD = 1'b1;
    tick(4);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    chk("rst_data", 32'(JOY_DATA), 1);
    chk("rst_bitcnt", 32'(bit_cnt), 0);
    chk("rst_done", 32'(frame_done), 0);
`ifdef JOY_DB15_TX_STATS_EN
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_short", 32'(short_frame), 0);
`endif
    // full frame: F = {7FF, FFE}, so bit 0 and bit 23 are 0
    joystick1 = 12'h001;
    joystick2 = 12'h800;
    load();
    d0 = done_cnt;
    chk("load_bitcnt", 32'(bit_cnt), 0);
    chk("frame_bit0", 32'(JOY_DATA), 0);
    JOY_CLK = 1'b1;
    tick(2);
    chk("latency_hold", 32'(JOY_DATA), 0);
    tick(1);
    chk("latency_shift", 32'(JOY_DATA), 1);
    chk("latency_bitcnt", 32'(bit_cnt), 1);
    tick(1);
    JOY_CLK = 1'b0;
    tick(4);
    for (int k = 1; k < 24; k++) begin
      chk($sformatf("frame_bit%0d", k), 32'(JOY_DATA), (k == 23) ? 0 : 1);
      if (k == 23) chk("done_early", 32'(done_cnt - d0), 0);
      pulse();
    end
    chk("frame_bitcnt", 32'(bit_cnt), 24);
    chk("frame_done_once", 32'(done_cnt - d0), 1);
    chk("frame_done_low", 32'(frame_done), 0);
    for (int k = 24; k < 30; k++) begin
      chk($sformatf("overrun_bit%0d", k), 32'(JOY_DATA), 1);
      pulse();
    end
    chk("overrun_bitcnt", 32'(bit_cnt), 24);
    chk("overrun_no_done", 32'(done_cnt - d0), 1);
    // clock edge during load is ignored; F[2] is 0
    joystick1 = 12'h004;
    joystick2 = 12'h000;
    JOY_LOAD = 1'b0;
    tick(4);
    pulse();
    chk("prio_bitcnt", 32'(bit_cnt), 0);
    chk("prio_data", 32'(JOY_DATA), 1);
    JOY_LOAD = 1'b1;
    tick(4);
    chk("prio_bit0", 32'(JOY_DATA), 1);
    pulse();
    chk("prio_bit1", 32'(JOY_DATA), 1);
    pulse();
    chk("prio_bit2", 32'(JOY_DATA), 0);
    chk("prio_bitcnt2", 32'(bit_cnt), 2);
    // data held after load release, inputs ignored
    joystick1 = 12'h001;
    load();
    joystick1 = 12'h000;
    tick(6);
    chk("hold_bit0", 32'(JOY_DATA), 0);
    // sample freeze mid-shift
    joystick1 = 12'h000;
    joystick2 = 12'h000;
    load();
    repeat (5) pulse();
    joystick1 = 12'hFFF;
    joystick2 = 12'hFFF;
    for (int k = 5; k < 24; k++) begin
      chk($sformatf("freeze_bit%0d", k), 32'(JOY_DATA), 1);
      pulse();
    end
    // reset mid-frame
    joystick1 = 12'h002;
    load();
    pulse();
    chk("mid_bit1", 32'(JOY_DATA), 0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("midrst_data", 32'(JOY_DATA), 1);
    chk("midrst_bitcnt", 32'(bit_cnt), 0);
    chk("midrst_done", 32'(frame_done), 0);
    tick(4);
    chk("midrst_idle", 32'(JOY_DATA), 1);
`ifdef JOY_DB15_TX_STATS_EN
    repeat (3) begin
      load();
      repeat (24) pulse();
    end
    chk("stats_no_short", 32'(short_frame), 0);
    load();
    repeat (10) pulse();
    load();
    chk("stats_frame_cnt", 32'(frame_cnt), 3);
    chk("stats_short", 32'(short_frame), 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("stats_rst_cnt", 32'(frame_cnt), 0);
    chk("stats_rst_short", 32'(short_frame), 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
